// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings and
// default latencies, also used by decode and stall logic.
package mul_div_unit_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int DEF_MULT_LAT = 5;
  localparam int DEF_DIV_LAT  = 10;

  function automatic logic is_mult(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers. The
// result is computed in the capture cycle and held pending until the counter expires.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [3:0]  Tnew,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  md_state_e   state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_valid_q, pend_valid_d;

  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, div_s, div_u;
  logic [31:0] quo_mag, rem_mag, quo_s, rem_s, quo_u, rem_u;

  // Signed division works on magnitudes so that quotient truncates toward
  // zero and 0x80000000 / -1 wraps to 0x80000000 without signed overflow.
  always_comb begin
    a_sx    = {{32{a[31]}}, a};
    b_sx    = {{32{b[31]}}, b};
    prod_s  = a_sx * b_sx;
    prod_u  = {32'd0, a} * {32'd0, b};
    a_neg   = a[31];
    b_neg   = b[31];
    a_mag   = a_neg ? (~a + 32'd1) : a;
    b_mag   = b_neg ? (~b + 32'd1) : b;
    div_s   = (b == 32'd0) ? 32'd1 : b_mag;
    div_u   = (b == 32'd0) ? 32'd1 : b;
    quo_mag = a_mag / div_s;
    rem_mag = a_mag % div_s;
    quo_s   = (a_neg ^ b_neg) ? (~quo_mag + 32'd1) : quo_mag;
    rem_s   = a_neg ? (~rem_mag + 32'd1) : rem_mag;
    quo_u   = a / div_u;
    rem_u   = a % div_u;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= 4'd0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      pend_hi_q    <= 32'd0;
      pend_lo_q    <= 32'd0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      pend_hi_q    <= pend_hi_d;
      pend_lo_q    <= pend_lo_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  // A divide by zero still occupies the unit but leaves pend_valid low so
  // the commit does not touch HI/LO.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    pend_hi_d    = pend_hi_q;
    pend_lo_d    = pend_lo_q;
    pend_valid_d = pend_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT: begin
              pend_hi_d    = prod_s[63:32];
              pend_lo_d    = prod_s[31:0];
              pend_valid_d = 1'b1;
              count_d      = 4'(MULT_LAT);
              state_d      = ST_BUSY;
            end
            OP_MULTU: begin
              pend_hi_d    = prod_u[63:32];
              pend_lo_d    = prod_u[31:0];
              pend_valid_d = 1'b1;
              count_d      = 4'(MULT_LAT);
              state_d      = ST_BUSY;
            end
            OP_DIV: begin
              pend_hi_d    = rem_s;
              pend_lo_d    = quo_s;
              pend_valid_d = (b != 32'd0);
              count_d      = 4'(DIV_LAT);
              state_d      = ST_BUSY;
            end
            OP_DIVU: begin
              pend_hi_d    = rem_u;
              pend_lo_d    = quo_u;
              pend_valid_d = (b != 32'd0);
              count_d      = 4'(DIV_LAT);
              state_d      = ST_BUSY;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          state_d = ST_IDLE;
          if (pend_valid_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stall logic sees the latency in the same cycle the instruction issues.
  always_comb begin
    Tnew = 4'd0;
    if (state_q == ST_BUSY)
      Tnew = count_q;
    else if (start && is_mult(op))
      Tnew = 4'(MULT_LAT);
    else if (start && is_div(op))
      Tnew = 4'(DIV_LAT);
  end

  assign busy = (state_q == ST_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
